// File: rtl/mem_register_read_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_register_read_pipe_pkg : shared types for the memory register-read pipe |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_register_read_pipe_pkg;

  typedef enum logic [1:0] {
    OOT_REG = 2'd0,
    OOT_IMM = 2'd1,
    OOT_PC  = 2'd2
  } OperandType;

  // The unused raw encoding 3 behaves as a register operand.
  function automatic OperandType decode_opnd_type(input logic [1:0] raw);
    case (raw)
      2'd1:    return OOT_IMM;
      2'd2:    return OOT_PC;
      default: return OOT_REG;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_register_read_pipe_flush.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flush_range_detector : active-list range check for selective flush         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module flush_range_detector #(
  parameter int AL_PTR_W = 6
) (
  input  logic                fl_active,
  input  logic                fl_all,
  input  logic [AL_PTR_W-1:0] fl_head,
  input  logic [AL_PTR_W-1:0] fl_tail,
  input  logic [AL_PTR_W-1:0] ptr,
  output logic                flush
);

  logic in_range;

  // head > tail means the range wraps past the top of the pointer space.
  always_comb begin
    if (fl_head <= fl_tail) begin
      in_range = (ptr >= fl_head) && (ptr < fl_tail);
    end else begin
      in_range = (ptr >= fl_head) || (ptr < fl_tail);
    end
    flush = fl_active && (fl_all || in_range);
  end

endmodule
`default_nettype wire

// File: rtl/mem_register_read_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_register_read_pipe : multi-lane register-read stage of the memory pipe |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_register_read_pipe
  import mem_register_read_pipe_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int RF_LAT    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int PREG_W    = 7,
  parameter int AL_PTR_W  = 6,
  parameter int PAYLOAD_W = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        clear,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]  in_payload,
  input  logic [LANES*AL_PTR_W-1:0]   in_al_ptr,
  input  logic [LANES*PREG_W-1:0]     in_src_a,
  input  logic [LANES*PREG_W-1:0]     in_src_b,
  input  logic [LANES*2-1:0]          in_type_a,
  input  logic [LANES*2-1:0]          in_type_b,
  input  logic [LANES*DATA_W-1:0]     in_imm,
  input  logic [LANES*ADDR_W-1:0]     in_pc,
  input  logic [LANES-1:0]            in_replay,
  input  logic [LANES-1:0]            in_is_div,
  input  logic                        fl_active,
  input  logic                        fl_all,
  input  logic [AL_PTR_W-1:0]         fl_head,
  input  logic [AL_PTR_W-1:0]         fl_tail,
  output logic [LANES*PREG_W-1:0]     rf_addr_a,
  output logic [LANES*PREG_W-1:0]     rf_addr_b,
  input  logic [LANES*(DATA_W+1)-1:0] rf_data_a,
  input  logic [LANES*(DATA_W+1)-1:0] rf_data_b,
  output logic [LANES-1:0]            out_valid,
  output logic [LANES*PAYLOAD_W-1:0]  out_payload,
  output logic [LANES*(DATA_W+1)-1:0] out_opnd_a,
  output logic [LANES*(DATA_W+1)-1:0] out_opnd_b,
  output logic [LANES-1:0]            out_replay,
  output logic [LANES-1:0]            div_release
);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [AL_PTR_W-1:0]  al_ptr;
    logic [PREG_W-1:0]    src_a;
    logic [PREG_W-1:0]    src_b;
    OperandType           type_a;
    OperandType           type_b;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic                 replay;
    logic                 is_div;
  } MemRrStageEntry;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } MemRrOperand;

  function automatic MemRrOperand sel_operand(
    input OperandType        t,
    input logic [DATA_W:0]   rf,
    input logic [DATA_W-1:0] imm,
    input logic [DATA_W-1:0] pc
  );
    MemRrOperand o;
    case (t)
      OOT_IMM: o = '{valid: 1'b1, data: imm};
      OOT_PC:  o = '{valid: 1'b1, data: pc};
      default: o = MemRrOperand'(rf);
    endcase
    return o;
  endfunction

  MemRrStageEntry stage_q  [RF_LAT][LANES];
  MemRrStageEntry stage_d  [RF_LAT][LANES];
  logic           valid_q  [RF_LAT][LANES];
  logic           valid_d  [RF_LAT][LANES];
  logic           stg_flush[RF_LAT][LANES];
  logic           in_flush [LANES];
  MemRrStageEntry in_entry [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    flush_range_detector #(.AL_PTR_W(AL_PTR_W)) u_in_flush (
      .fl_active (fl_active),
      .fl_all    (fl_all),
      .fl_head   (fl_head),
      .fl_tail   (fl_tail),
      .ptr       (in_al_ptr[l*AL_PTR_W +: AL_PTR_W]),
      .flush     (in_flush[l])
    );
    for (genvar k = 0; k < RF_LAT; k++) begin : g_stage
      flush_range_detector #(.AL_PTR_W(AL_PTR_W)) u_stg_flush (
        .fl_active (fl_active),
        .fl_all    (fl_all),
        .fl_head   (fl_head),
        .fl_tail   (fl_tail),
        .ptr       (stage_q[k][l].al_ptr),
        .flush     (stg_flush[k][l])
      );
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      in_entry[l].payload = in_payload[l*PAYLOAD_W +: PAYLOAD_W];
      in_entry[l].al_ptr  = in_al_ptr[l*AL_PTR_W +: AL_PTR_W];
      in_entry[l].src_a   = in_src_a[l*PREG_W +: PREG_W];
      in_entry[l].src_b   = in_src_b[l*PREG_W +: PREG_W];
      in_entry[l].type_a  = decode_opnd_type(in_type_a[l*2 +: 2]);
      in_entry[l].type_b  = decode_opnd_type(in_type_b[l*2 +: 2]);
      in_entry[l].imm     = in_imm[l*DATA_W +: DATA_W];
      in_entry[l].pc      = DATA_W'(in_pc[l*ADDR_W +: ADDR_W]);
      in_entry[l].replay  = in_replay[l];
      in_entry[l].is_div  = in_is_div[l];
    end
  end

  // Flushed ops are dropped in place while stalled, or simply not carried forward on advance.
  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (clear) begin
      for (int k = 0; k < RF_LAT; k++)
        for (int l = 0; l < LANES; l++)
          valid_d[k][l] = 1'b0;
    end else if (stall) begin
      for (int k = 0; k < RF_LAT; k++)
        for (int l = 0; l < LANES; l++)
          valid_d[k][l] = valid_q[k][l] & ~stg_flush[k][l];
    end else begin
      for (int l = 0; l < LANES; l++) begin
        stage_d[0][l] = in_entry[l];
        valid_d[0][l] = in_valid[l] & ~in_flush[l];
        for (int k = 1; k < RF_LAT; k++) begin
          stage_d[k][l] = stage_q[k-1][l];
          valid_d[k][l] = valid_q[k-1][l] & ~stg_flush[k-1][l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RF_LAT; k++)
        for (int l = 0; l < LANES; l++)
          valid_q[k][l] <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
    stage_q <= stage_d;
  end

  always_comb begin
    out_valid   = '0;
    out_replay  = '0;
    out_payload = '0;
    out_opnd_a  = '0;
    out_opnd_b  = '0;
    rf_addr_a   = '0;
    rf_addr_b   = '0;
    div_release = '0;
    for (int l = 0; l < LANES; l++) begin
      logic rel;
      out_valid[l]  = valid_q[RF_LAT-1][l] & ~stall & ~clear & ~rst & ~stg_flush[RF_LAT-1][l];
      out_replay[l] = out_valid[l] & stage_q[RF_LAT-1][l].replay;
      out_payload[l*PAYLOAD_W +: PAYLOAD_W] = stage_q[RF_LAT-1][l].payload;
      out_opnd_a[l*(DATA_W+1) +: DATA_W+1] = sel_operand(stage_q[RF_LAT-1][l].type_a,
          rf_data_a[l*(DATA_W+1) +: DATA_W+1], stage_q[RF_LAT-1][l].imm, stage_q[RF_LAT-1][l].pc);
      out_opnd_b[l*(DATA_W+1) +: DATA_W+1] = sel_operand(stage_q[RF_LAT-1][l].type_b,
          rf_data_b[l*(DATA_W+1) +: DATA_W+1], stage_q[RF_LAT-1][l].imm, stage_q[RF_LAT-1][l].pc);
      rf_addr_a[l*PREG_W +: PREG_W] = stage_q[0][l].src_a;
      rf_addr_b[l*PREG_W +: PREG_W] = stage_q[0][l].src_b;
      // A divider op flushed on its way into S1 never occupies a stage, so release it here.
      rel = in_valid[l] & in_is_div[l] & in_flush[l] & ~stall & ~clear;
      for (int k = 0; k < RF_LAT; k++)
        rel = rel | (valid_q[k][l] & stage_q[k][l].is_div & (stg_flush[k][l] | clear));
      div_release[l] = rel & ~rst;
    end
  end

endmodule
`default_nettype wire
